// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared MMIO addresses, UART status bit positions and UART TX
//            serializer state type.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [31:0] UART_TX_ADDR   = 32'h1000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;

    localparam int UART_STAT_FULL  = 0;
    localparam int UART_STAT_EMPTY = 1;
    localparam int UART_STAT_BUSY  = 2;
    localparam int UART_STAT_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Packs the UART flags into the layout returned on a status-register read
    function automatic logic [3:0] uart_status(input logic full, input logic empty,
                                               input logic busy, input logic ovf);
        logic [3:0] s;
        s                  = '0;
        s[UART_STAT_FULL]  = full;
        s[UART_STAT_EMPTY] = empty;
        s[UART_STAT_BUSY]  = busy;
        s[UART_STAT_OVF]   = ovf;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock circular FIFO with extra-bit pointers and a
//            combinational head-of-queue read port.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = wr_en && !full;
    assign w_pop  = rd_en && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (c_AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[c_AW-1:0]] <= wr_data;
    end

    // Pointers differ only in the wrap bit when the buffer is full
    assign rd_data = r_mem[r_rptr[c_AW-1:0]];
    assign level   = r_wptr - r_rptr;
    assign empty   = (r_wptr == r_rptr);
    assign full    = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : 8N1 UART transmitter fed by a byte FIFO from the MMIO store path.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
    import riscv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic                        clr_ovf,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        overflow,
    output logic                        tx
);

    localparam int              c_BW        = $clog2(CLKS_PER_BIT);
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);

    uart_state_t     r_state;
    uart_state_t     w_state_nxt;
    logic [c_BW-1:0] r_baud;
    logic [c_BW-1:0] w_baud_nxt;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            r_ovf;
    logic            w_pop;
    logic [7:0]      w_head;
    logic            w_baud_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign w_baud_done = (r_baud == c_BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // tx is registered from its next value so the pin never sees a combinational path
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + c_BW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (!empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = START;
                    w_tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (!empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // A dropped push outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (wr_en && full) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign busy     = (r_state != IDLE);
    assign overflow = r_ovf;
    assign tx       = r_tx;

endmodule
`default_nettype wire
